// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// mips_mem_pkg -- memory-map constants and store-buffer entry type
// Rev 1.0
// ============================================================================
package mips_mem_pkg;

   localparam logic [7:0] ADDR_PORT0   = 8'hFD;
   localparam logic [7:0] ADDR_PORT1   = 8'hFE;
   localparam logic [7:0] ADDR_OUTPORT = 8'hFF;

   // Entry fields are sized for the widest supported configuration; narrower
   // instances zero-extend into them and the unused upper bits are constant.
   localparam int SB_MAX_AW = 16;
   localparam int SB_MAX_DW = 64;

   typedef struct packed {
      logic                 valid;
      logic [SB_MAX_AW-1:0] addr;
      logic [SB_MAX_DW-1:0] data;
   } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_buffer_match.sv
`default_nettype none
// ============================================================================
// store_buffer_match -- address compare with youngest-entry priority select
// Rev 1.0
// ============================================================================
module store_buffer_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   parameter int DW    = 32,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]         valid,
   input  logic [DEPTH-1:0][AW-1:0] addr,
   input  logic [DEPTH-1:0][DW-1:0] data,
   input  logic [PW-1:0]            oldest,
   input  logic [AW-1:0]            ld_addr,
   output logic                     hit,
   output logic [DW-1:0]            hit_data
);

   logic [DEPTH-1:0] eq;
   logic [PW-1:0]    idx;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
         assign eq[i] = valid[i] && (addr[i] == ld_addr);
      end
   endgenerate

   // Walk from the tail slot forward (oldest to youngest); the last match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = oldest + PW'(k);
         if (eq[idx]) begin
            hit      = 1'b1;
            hit_data = data[idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// store_buffer -- circular store FIFO draining into the data memory port.
// Optional macro STORE_BUFFER_FWD_EN: forward matching store data to loads.
// Rev 1.0
// ============================================================================
module store_buffer
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          st_ready,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_fwd_valid,
   output logic [DW-1:0] ld_fwd_data,
   output logic          ld_stall,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data_in,
   output logic          mem_write_en,
   output logic          empty,
   output logic          ro_drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sb_entry_t     entries_q [DEPTH];
   sb_entry_t     entries_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ro_drop_q, ro_drop_d;

   logic          is_ro, push, pop;
   sb_entry_t     head_ent;
   logic [DEPTH-1:0]         ent_valid;
   logic [DEPTH-1:0][AW-1:0] ent_addr;
   logic [DEPTH-1:0][DW-1:0] ent_data;
   logic          hit;
   logic [DW-1:0] hit_data;
   logic          unused_entry_bits;

   assign st_ready = (count_q != CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign ro_drop  = ro_drop_q;
   assign is_ro    = (st_addr == AW'(ADDR_PORT0)) || (st_addr == AW'(ADDR_PORT1));
   assign push     = st_valid && st_ready && !is_ro;
   // Holding the drain off during reset keeps discarded stores out of memory.
   assign pop      = !rst && !ld_valid && !empty;
   assign head_ent = entries_q[head_q];

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
         assign ent_valid[i] = entries_q[i].valid;
         assign ent_addr[i]  = entries_q[i].addr[AW-1:0];
         assign ent_data[i]  = entries_q[i].data[DW-1:0];
      end
   endgenerate

   always_comb begin
      unused_entry_bits = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         unused_entry_bits = unused_entry_bits ^ (^entries_q[i].addr) ^ (^entries_q[i].data);
      end
   end

   // The tail slot is the oldest position when full and invalid otherwise.
   store_buffer_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_match (
      .valid    (ent_valid),
      .addr     (ent_addr),
      .data     (ent_data),
      .oldest   (tail_q),
      .ld_addr  (ld_addr),
      .hit      (hit),
      .hit_data (hit_data)
   );

`ifdef STORE_BUFFER_FWD_EN
   assign ld_fwd_valid = hit;
   assign ld_fwd_data  = hit_data;
   assign ld_stall     = 1'b0;
`else
   logic unused_hit_data;
   assign unused_hit_data = ^hit_data;
   assign ld_fwd_valid    = 1'b0;
   assign ld_fwd_data     = '0;
   assign ld_stall        = hit;
`endif

   always_comb begin
      mem_write_en = 1'b0;
      mem_addr     = '0;
      mem_data_in  = '0;
      if (ld_valid) begin
         mem_addr = ld_addr;
      end else if (pop) begin
         mem_write_en = 1'b1;
         mem_addr     = head_ent.addr[AW-1:0];
         mem_data_in  = head_ent.data[DW-1:0];
      end
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      ro_drop_d = st_valid && st_ready && is_ro;
      if (push) begin
         entries_d[tail_q].valid = 1'b1;
         entries_d[tail_q].addr  = SB_MAX_AW'(st_addr);
         entries_d[tail_q].data  = SB_MAX_DW'(st_data);
         tail_d                  = tail_q + PW'(1);
      end
      if (pop) begin
         entries_d[head_q].valid = 1'b0;
         head_d                  = head_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         ro_drop_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i].valid <= 1'b0;
         end
      end else begin
         count_q   <= count_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         ro_drop_q <= ro_drop_d;
         entries_q <= entries_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, power of two ≥2; the number of buffered stores.
REQ-002 SHALL have parameter AW, default 8, the data-memory address width.
REQ-003 SHALL have parameter DW, default 32, the data width.
REQ-004 SHALL use one clock; reset is synchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_valid  in  1  pipeline presents a store
- st_addr  in  AW  store address
- st_data  in  DW  store data
- st_ready  out  1  store accepted this cycle when st_valid=1
- ld_valid  in  1  pipeline load owns the memory address port this cycle
- ld_addr  in  AW  load address
- ld_fwd_valid  out  1  ld_fwd_data is valid
- ld_fwd_data  out  DW  forwarded store data
- ld_stall  out  1  load must be held
- mem_addr  out  AW  to memory unit addr
- mem_data_in  out  DW  to memory unit data_in
- mem_write_en  out  1  to memory unit write_en
- empty  out  1  no pending stores
- ro_drop  out  1  one-cycle pulse: store to a read-only port dropped

Function
REQ-006 SHALL hold stores in a circular FIFO: head/tail pointers modulo DEPTH, count 0..DEPTH.
REQ-007 st_ready SHALL equal (count != DEPTH); there is no pass-through when full, even if a drain occurs in the same cycle.
REQ-008 A store with st_valid and st_ready SHALL be pushed at the clock edge.
- Exception: addresses 0xFD and 0xFE are input ports. Such a store SHALL be accepted, not pushed, and SHALL pulse ro_drop in the next cycle.
REQ-009 A store to 0xFF (output port) SHALL be buffered and drained like a RAM store.
REQ-010 Drain: when count>0 and ld_valid=0, the block SHALL drive mem_write_en=1, mem_addr=head addr and mem_data_in=head data combinationally, and SHALL pop at the clock edge.
- Rate: one write per cycle.
REQ-011 When ld_valid=1, mem_write_en SHALL be 0 and mem_addr SHALL equal ld_addr, so loads have priority.
REQ-012 Otherwise, when count=0, mem_write_en=0 and mem_addr=0.
REQ-013 Latency: a store pushed at edge N SHALL appear on mem_write_en no earlier than cycle N+1.
REQ-014 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-015 Load lookup SHALL be combinational against valid entries only. With multiple matches, the youngest entry wins.
REQ-016 A store being pushed in the same cycle SHALL NOT be visible to the lookup.
REQ-017 The head entry being drained in the same cycle SHALL still match.
REQ-018 empty SHALL equal (count==0).

Reset
REQ-019 On rst, at the clock edge:
- count, head and tail SHALL be cleared to 0;
- all entry valid bits SHALL be cleared;
- ro_drop SHALL be 0.
REQ-020 On reset mid-operation, pending stores SHALL be discarded and never written. In the cycle after the reset edge, mem_write_en=0, st_ready=1, empty=1, ld_fwd_valid=0 and ld_stall=0.

Configuration
REQ-021 With macro STORE_BUFFER_FWD_EN defined, a lookup match SHALL give ld_fwd_valid=1, ld_fwd_data=youngest matching data, ld_stall=0.
REQ-022 Without STORE_BUFFER_FWD_EN:
- ld_fwd_valid SHALL be tied 0 and ld_fwd_data tied 0;
- a lookup match SHALL assert ld_stall until no matching entry remains.

Structure
REQ-023 Shared package mips_mem_pkg SHALL hold:
- constants ADDR_PORT0=8'hFD, ADDR_PORT1=8'hFE, ADDR_OUTPORT=8'hFF;
- typedef sb_entry_t containing valid, addr and data.
REQ-024 One sub-module, store_buffer_match, SHALL perform the address compare and youngest-match priority select. It is parameterised by DEPTH.

Verification
REQ-025 Fill test: push stores 0x10/0x11111111, 0x40/0x22222222, 0x80/0x33333333, 0xC0/0x44444444 with ld_valid=1 held. Required: st_ready=0 after the fourth store. After ld_valid is released, four consecutive mem_write_en cycles occur in FIFO order, then empty=1.
REQ-026 Forwarding test: push 0x20/0xAAAA0001 then 0x20/0xAAAA0002; hold drain with ld_valid and ld_addr=0x20. Required with FWD_EN: ld_fwd_data=0xAAAA0002. Required without FWD_EN: ld_stall=1 until both entries drain.
REQ-027 Read-only port test: store to 0xFD/0xDEADBEEF. Required: ro_drop pulses for one cycle, empty stays 1, and mem_write_en never fires.
REQ-028 Output-port test: store 0xFF/0xAABBCCDD with the memory unit attached. Required: the memory unit's output_port reads 0xAABBCCDD two cycles later.
REQ-029 Simultaneous test: with count=2, push and drain in the same cycle. Required: count stays 2 and the ordering is preserved.
REQ-030 Reset test: assert rst with count=3. Required: in the next cycle empty=1, mem_write_en=0, and no discarded store ever reaches memory.
